// File: rtl/lifo_access_arbiter_if.sv
// Client request and LIFO-side signal bundle for lifo_access_arbiter.
// master = clients plus attached LIFO (environment), slave = arbiter.
interface lifo_access_arbiter_if #(
   parameter int Input_Data_Width = 8,
   parameter int LIFO_Depth       = 13,
   parameter int Num_Requesters   = 4
);
   localparam int GW = $clog2(Num_Requesters);
   localparam int CW = $clog2(LIFO_Depth + 1);

   logic [Num_Requesters-1:0]                  Req_Write;
   logic [Num_Requesters-1:0]                  Req_Read;
   logic [Num_Requesters*Input_Data_Width-1:0] Req_Data_in;
   logic [Num_Requesters-1:0]                  Req_Ack;
   logic                                       Req_Error;
   logic [Input_Data_Width-1:0]                Rd_Data;
   logic                                       Rd_Valid;
   logic [GW-1:0]                              Grant_Id;
   logic                                       Busy;
   logic [CW-1:0]                              Count;
   logic                                       LIFO_Write;
   logic                                       LIFO_Read;
   logic [Input_Data_Width-1:0]                LIFO_Data_in;
   logic                                       LIFO_Full;
   logic                                       LIFO_Empty;
   logic [Input_Data_Width-1:0]                LIFO_Data_out;

   modport master (
      output Req_Write, Req_Read, Req_Data_in, LIFO_Full, LIFO_Empty, LIFO_Data_out,
      input  Req_Ack, Req_Error, Rd_Data, Rd_Valid, Grant_Id, Busy, Count,
             LIFO_Write, LIFO_Read, LIFO_Data_in
   );

   modport slave (
      input  Req_Write, Req_Read, Req_Data_in, LIFO_Full, LIFO_Empty, LIFO_Data_out,
      output Req_Ack, Req_Error, Rd_Data, Rd_Valid, Grant_Id, Busy, Count,
             LIFO_Write, LIFO_Read, LIFO_Data_in
   );
endinterface

// File: rtl/lifo_access_arbiter.sv
// Round-robin arbiter sharing one LIFO between clients; one strobe + low cycle per grant.
// Latency: accepted op 4 cycles request-to-ack, rejected (full/empty) op 2 cycles.
// Backpressure: clients hold level requests until Req_Ack; LIFO_ARB_FIXED_PRIO_EN selects fixed priority.
module lifo_access_arbiter #(
   parameter int Input_Data_Width = 8,
   parameter int LIFO_Depth       = 13,
   parameter int Num_Requesters   = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   lifo_access_arbiter_if.slave bus
);
   localparam int GW = $clog2(Num_Requesters);
   localparam int CW = $clog2(LIFO_Depth + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(LIFO_Depth);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   state_e                      state_q, state_d;
   logic [GW-1:0]               grant_q;
   logic                        pop_q;
   logic                        err_q;
   logic [Input_Data_Width-1:0] data_q;
   logic [Input_Data_Width-1:0] rd_data_q;
   logic [CW-1:0]               count_q;

   logic [Num_Requesters-1:0]   pending;
   logic                        sel_vld;
   logic [GW-1:0]               sel_id;
   logic                        sel_push;
   logic                        sel_reject;

`ifdef LIFO_ARB_FIXED_PRIO_EN
   // Descending scan so the lowest pending index is the last (winning) write.
   always_comb begin
      pending = bus.Req_Write | bus.Req_Read;
      sel_vld = 1'b0;
      sel_id  = '0;
      for (int i = Num_Requesters - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel_vld = 1'b1;
            sel_id  = GW'(i);
         end
      end
   end
`else
   logic [GW-1:0] ptr_q;
   logic [GW-1:0] cand;

   // Search starts one past the last grant and wraps at Num_Requesters.
   always_comb begin
      pending = bus.Req_Write | bus.Req_Read;
      sel_vld = 1'b0;
      sel_id  = '0;
      cand    = '0;
      for (int k = 1; k <= Num_Requesters; k++) begin
         cand = GW'((int'(ptr_q) + k) % Num_Requesters);
         if (!sel_vld && pending[cand]) begin
            sel_vld = 1'b1;
            sel_id  = cand;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ptr_q <= GW'(Num_Requesters - 1);
      end else if (state_q == IDLE && sel_vld) begin
         ptr_q <= sel_id;
      end
   end
`endif

   // A client holding both requests gets its push first.
   assign sel_push   = bus.Req_Write[sel_id];
   assign sel_reject = sel_push ? bus.LIFO_Full : bus.LIFO_Empty;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sel_vld) state_d = sel_reject ? DONE : ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.Req_Ack    = '0;
      bus.Req_Error  = 1'b0;
      bus.Rd_Valid   = 1'b0;
      bus.LIFO_Write = 1'b0;
      bus.LIFO_Read  = 1'b0;
      case (state_q)
         ISSUE: begin
            bus.LIFO_Write = !pop_q;
            bus.LIFO_Read  = pop_q;
         end
         DONE: begin
            bus.Req_Ack[grant_q] = 1'b1;
            bus.Req_Error        = err_q;
            bus.Rd_Valid         = pop_q && !err_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         grant_q   <= '0;
         pop_q     <= 1'b0;
         err_q     <= 1'b0;
         data_q    <= '0;
         rd_data_q <= '0;
         count_q   <= '0;
      end else begin
         if (state_q == IDLE && sel_vld) begin
            grant_q <= sel_id;
            pop_q   <= !sel_push;
            err_q   <= sel_reject;
            data_q  <= bus.Req_Data_in[int'(sel_id)*Input_Data_Width +: Input_Data_Width];
         end
         // Occupancy mirror only; Full/Empty still decide accept/reject.
         if (state_q == ISSUE) begin
            if (pop_q && count_q != '0) begin
               count_q <= count_q - 1'b1;
            end else if (!pop_q && count_q != DEPTH_C) begin
               count_q <= count_q + 1'b1;
            end
         end
         if (state_q == WAIT && pop_q) begin
            rd_data_q <= bus.LIFO_Data_out;
         end
      end
   end

   assign bus.Grant_Id     = grant_q;
   assign bus.Busy         = (state_q != IDLE);
   assign bus.Count        = count_q;
   assign bus.Rd_Data      = rd_data_q;
   assign bus.LIFO_Data_in = data_q;

endmodule

// File: tb/tb_lifo_access_arbiter.sv
// Directed scoreboard bench for lifo_access_arbiter with a behavioural 13-deep LIFO attached.
module tb_lifo_access_arbiter;
   localparam int W = 8;
   localparam int D = 13;
   localparam int N = 4;

   typedef struct {
      int id;
      bit err;
      bit rdv;
      int rdat;
      int cnt;
   } exp_t;

   typedef struct {
      logic [127:0] name;
      int act;
      int exp;
   } dchk_t;

   logic clk;
   logic reset_n;
   logic [N-1:0]   req_w;
   logic [N-1:0]   req_r;
   logic [N*W-1:0] req_din;

   exp_t  sb[$];
   dchk_t dq[$];
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int wr_pulses = 0;
   int rd_pulses = 0;
   int last_wr_cyc = -1;
   int last_wr_dat = -1;
   int last_ack_cyc = -1;

   lifo_access_arbiter_if #(.Input_Data_Width(W), .LIFO_Depth(D), .Num_Requesters(N)) bus ();

   lifo_access_arbiter #(.Input_Data_Width(W), .LIFO_Depth(D), .Num_Requesters(N)) dut (
      .clk_i   (clk),
      .reset_ni(reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Attached LIFO: registered read data, writes/reads taken on the rising edge.
   logic [W-1:0] mem [0:D-1];
   int           sp;
   logic [W-1:0] dout;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sp   <= 0;
         dout <= '0;
      end else if (bus.LIFO_Write && sp < D) begin
         mem[sp] <= bus.LIFO_Data_in;
         sp      <= sp + 1;
      end else if (bus.LIFO_Read && sp > 0) begin
         dout <= mem[sp-1];
         sp   <= sp - 1;
      end
   end

   assign bus.LIFO_Full     = (sp == D);
   assign bus.LIFO_Empty    = (sp == 0);
   assign bus.LIFO_Data_out = dout;
   assign bus.Req_Write     = req_w;
   assign bus.Req_Read      = req_r;
   assign bus.Req_Data_in   = req_din;

   task automatic cmp(input logic [127:0] nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %0s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: the only process that compares.
   always @(negedge clk) begin
      exp_t  e;
      dchk_t d;
      while (dq.size() > 0) begin
         d = dq.pop_front();
         cmp(d.name, d.act, d.exp);
      end
      if (bus.LIFO_Write) begin
         wr_pulses   <= wr_pulses + 1;
         last_wr_cyc <= cyc;
         last_wr_dat <= int'(bus.LIFO_Data_in);
      end
      if (bus.LIFO_Read) rd_pulses <= rd_pulses + 1;
      if (|bus.Req_Ack) begin
         last_ack_cyc <= cyc;
         if (sb.size() == 0) begin
            cmp("unexpected_ack", int'(bus.Req_Ack), 0);
         end else begin
            e = sb.pop_front();
            cmp("ack_vector", int'(bus.Req_Ack), 1 << e.id);
            cmp("grant_id", int'(bus.Grant_Id), e.id);
            cmp("req_error", int'(bus.Req_Error), int'(e.err));
            cmp("rd_valid", int'(bus.Rd_Valid), int'(e.rdv));
            if (e.rdv) cmp("rd_data", int'(bus.Rd_Data), e.rdat);
            cmp("count", int'(bus.Count), e.cnt);
         end
      end
   end

   task automatic dchk(input logic [127:0] nm, input int act, input int exp);
      dchk_t d;
      d.name = nm;
      d.act  = act;
      d.exp  = exp;
      dq.push_back(d);
   endtask

   task automatic expect_ack(input int id, input bit err, input bit rdv, input int rdat, input int cnt);
      exp_t e;
      e.id   = id;
      e.err  = err;
      e.rdv  = rdv;
      e.rdat = rdat;
      e.cnt  = cnt;
      sb.push_back(e);
   endtask

   task automatic req(input int c, input bit wr, input int dat);
      if (wr) req_w[c] = 1'b1;
      else    req_r[c] = 1'b1;
      req_din[c*W +: W] = W'(dat);
   endtask

   // Release each client right after the edge on which its ack is sampled.
   task automatic drain(input int budget);
      logic [N-1:0] m;
      int n = 0;
      while ((req_w | req_r) != '0 && n < budget) begin
         @(negedge clk);
         m = bus.Req_Ack;
         @(posedge clk);
         #1;
         req_w = req_w & ~m;
         req_r = req_r & ~m;
         n++;
      end
      if ((req_w | req_r) != '0) begin
         dchk("drain_timeout", 1, 0);
         req_w = '0;
         req_r = '0;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req_w   = '0;
      req_r   = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   int c0, w0, r0, acks, n;
   int exp_ids[5];

   initial begin
      reset_n = 1'b0;
      req_w   = '0;
      req_r   = '0;
      req_din = '0;
      #2;
      dchk("rst_strobes", int'({bus.Req_Ack, bus.Req_Error, bus.Rd_Valid, bus.Busy,
                                bus.LIFO_Write, bus.LIFO_Read}), 0);
      dchk("rst_count", int'(bus.Count), 0);
      dchk("rst_rd_data", int'(bus.Rd_Data), 0);
      dchk("rst_grant_dat", int'({bus.Grant_Id, bus.LIFO_Data_in}), 0);
      do_reset();

      // Single push: strobe in cycle 2, ack in cycle 4.
      c0 = cyc;
      w0 = wr_pulses;
      req(0, 1, 10);
      expect_ack(0, 0, 0, 0, 1);
      drain(20);
      @(negedge clk);
      dchk("t1_wr_latency", last_wr_cyc - c0, 1);
      dchk("t1_wr_data", last_wr_dat, 10);
      dchk("t1_ack_latency", last_ack_cyc - c0, 3);
      dchk("t1_wr_pulses", wr_pulses - w0, 1);

      // Simultaneous pushes from 1 and 2, then pop by 3.
      do_reset();
      req(1, 1, 20);
      req(2, 1, 30);
      expect_ack(1, 0, 0, 0, 1);
      expect_ack(2, 0, 0, 0, 2);
      drain(40);
      req(3, 0, 0);
      expect_ack(3, 0, 1, 30, 1);
      drain(20);

      // All four clients requesting continuously.
      do_reset();
`ifdef LIFO_ARB_FIXED_PRIO_EN
      exp_ids = '{0, 0, 0, 0, 0};
`else
      exp_ids = '{0, 1, 2, 3, 0};
`endif
      for (int i = 0; i < 5; i++) expect_ack(exp_ids[i], 0, 0, 0, i + 1);
      for (int i = 0; i < N; i++) req(i, 1, 50 + i);
      acks = 0;
      n = 0;
      while (acks < 5 && n < 60) begin
         @(negedge clk);
         if (|bus.Req_Ack) acks++;
         @(posedge clk);
         #1;
         n++;
      end
      req_w = '0;
      dchk("t3_ack_total", acks, 5);

      // Fill to 13, then an overflow push of 45 by client 1.
      do_reset();
      for (int k = 1; k <= D; k++) begin
         req(0, 1, k);
         expect_ack(0, 0, 0, 0, k);
         drain(20);
      end
      w0 = wr_pulses;
      c0 = cyc;
      req(1, 1, 45);
      expect_ack(1, 1, 0, 0, D);
      drain(20);
      @(negedge clk);
      dchk("ovf_ack_latency", last_ack_cyc - c0, 1);
      dchk("ovf_no_write", wr_pulses - w0, 0);
      req(2, 0, 0);
      expect_ack(2, 0, 1, 13, D - 1);
      drain(20);

      // Pop on an empty LIFO must leave Rd_Data alone.
      do_reset();
      req(1, 1, 77);
      expect_ack(1, 0, 0, 0, 1);
      drain(20);
      req(2, 0, 0);
      expect_ack(2, 0, 1, 77, 0);
      drain(20);
      r0 = rd_pulses;
      req(3, 0, 0);
      expect_ack(3, 1, 0, 0, 0);
      drain(20);
      @(negedge clk);
      dchk("udf_no_read", rd_pulses - r0, 0);
      dchk("udf_rd_data_held", int'(bus.Rd_Data), 77);

      // Reset in the middle of ISSUE for a push.
      do_reset();
      req(0, 1, 99);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.LIFO_Write && n < 10);
      dchk("irq_saw_write", int'(bus.LIFO_Write), 1);
      #1;
      reset_n = 1'b0;
      #1;
      dchk("irq_write_drop", int'(bus.LIFO_Write), 0);
      dchk("irq_busy_drop", int'(bus.Busy), 0);
      req_w = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      dchk("irq_count", int'(bus.Count), 0);
      dchk("irq_lifo_untouched", sp, 0);
      reset_n = 1'b1;
      req(3, 1, 5);
      req(0, 1, 6);
      expect_ack(0, 0, 0, 0, 1);
      expect_ack(3, 0, 0, 0, 2);
      drain(40);

      repeat (3) @(posedge clk);
      dchk("sb_empty", sb.size(), 0);
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_err);
      $fatal(1);
   end
endmodule
